// File: rtl/scale_mux_ctrl.sv
// Handshake controller around a scale_mux: arbitrates sources A/B onto SEL and
// registers the mux result into a single-entry valid/ready output stage.
module scale_mux_ctrl #(
  parameter int SIZE = 1,
  parameter bit RR   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            a_valid_i,
  output logic            a_ready_o,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  output logic            sel_o,
  input  logic [SIZE-1:0] mux_in_i,
  output logic [SIZE-1:0] out_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);

  logic [SIZE-1:0] out_q, out_d;
  logic            vld_q, vld_d;
  logic            last_q, last_d;
  logic            sel_q, sel_d;
  logic            space;
  logic            gnt_a, gnt_b, xfer;

  assign space = ~vld_q | out_ready_i;

  // Grants are qualified by space and reset so a stalled or resetting stage
  // neither asserts ready nor moves SEL.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n_i && space) begin
      if (a_valid_i && b_valid_i) begin
        if (RR && !last_q) gnt_b = 1'b1;
        else               gnt_a = 1'b1;
      end else if (a_valid_i) begin
        gnt_a = 1'b1;
      end else if (b_valid_i) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign xfer      = gnt_a | gnt_b;
  assign a_ready_o = gnt_a;
  assign b_ready_o = gnt_b;
  // Idle SEL replays the last driven value; independent of mux_in_i.
  assign sel_o     = xfer ? gnt_b : sel_q;

  always_comb begin
    out_d  = out_q;
    vld_d  = vld_q;
    last_d = last_q;
    sel_d  = sel_q;
    if (xfer) begin
      out_d  = mux_in_i;
      vld_d  = 1'b1;
      last_d = gnt_b;
      sel_d  = gnt_b;
    end else if (out_ready_i) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b1;
      sel_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      sel_q  <= sel_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = vld_q;

endmodule

// File: tb/tb_scale_mux_ctrl.sv
// Directed bench for scale_mux_ctrl: a round-robin instance and a fixed-priority
// instance, each fed by a behavioural mux selecting between constant A/B data.
module tb_scale_mux_ctrl;
  localparam int SIZE = 8;
  localparam logic [SIZE-1:0] A_DATA = 8'h11;
  localparam logic [SIZE-1:0] B_DATA = 8'h22;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // round-robin instance
  logic r_av, r_ar, r_bv, r_br, r_sel, r_ov, r_or;
  logic [SIZE-1:0] r_min, r_out;
  // fixed-priority instance
  logic f_av, f_ar, f_bv, f_br, f_sel, f_ov, f_or;
  logic [SIZE-1:0] f_min, f_out;

  assign r_min = r_sel ? B_DATA : A_DATA;
  assign f_min = f_sel ? B_DATA : A_DATA;

  scale_mux_ctrl #(.SIZE(SIZE), .RR(1'b1)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_valid_i(r_av), .a_ready_o(r_ar), .b_valid_i(r_bv), .b_ready_o(r_br),
    .sel_o(r_sel), .mux_in_i(r_min), .out_o(r_out), .out_valid_o(r_ov),
    .out_ready_i(r_or)
  );

  scale_mux_ctrl #(.SIZE(SIZE), .RR(1'b0)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_valid_i(f_av), .a_ready_o(f_ar), .b_valid_i(f_bv), .b_ready_o(f_br),
    .sel_o(f_sel), .mux_in_i(f_min), .out_o(f_out), .out_valid_o(f_ov),
    .out_ready_i(f_or)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    r_av = 0; r_bv = 0; r_or = 1;
    f_av = 0; f_bv = 0; f_or = 1;
    repeat (2) tick();
    #1;
    chk("rst_out", r_out, 8'h00);
    chk("rst_ov", {7'd0, r_ov}, 8'd0);
    chk("rst_sel", {7'd0, r_sel}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Alternation: both valid, sink always ready
    r_av = 1; r_bv = 1; r_or = 1;
    #1;
    chk("alt0_sel", {7'd0, r_sel}, 8'd0);
    chk("alt0_ar", {7'd0, r_ar}, 8'd1);
    chk("alt0_br", {7'd0, r_br}, 8'd0);
    tick();
    chk("alt1_out", r_out, 8'h11);
    chk("alt1_ov", {7'd0, r_ov}, 8'd1);
    chk("alt1_sel", {7'd0, r_sel}, 8'd1);
    chk("alt1_br", {7'd0, r_br}, 8'd1);
    tick();
    chk("alt2_out", r_out, 8'h22);
    chk("alt2_sel", {7'd0, r_sel}, 8'd0);
    tick();
    chk("alt3_out", r_out, 8'h11);

    // Backpressure: OUT=0x11, next would be B but sink stalls
    r_or = 0;
    #1;
    chk("bp_ar", {7'd0, r_ar}, 8'd0);
    chk("bp_br", {7'd0, r_br}, 8'd0);
    chk("bp_sel", {7'd0, r_sel}, 8'd0);
    tick();
    chk("bp_out", r_out, 8'h11);
    chk("bp_ov", {7'd0, r_ov}, 8'd1);
    chk("bp_sel2", {7'd0, r_sel}, 8'd0);
    r_or = 1;
    #1;
    chk("bp_rel_br", {7'd0, r_br}, 8'd1);
    chk("bp_rel_sel", {7'd0, r_sel}, 8'd1);
    tick();
    chk("bp_rel_out", r_out, 8'h22);

    // Single source B for three cycles, then A alone
    r_av = 0; r_bv = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sb_sel", {7'd0, r_sel}, 8'd1);
      chk("sb_br", {7'd0, r_br}, 8'd1);
      chk("sb_ar", {7'd0, r_ar}, 8'd0);
      tick();
      chk("sb_out", r_out, 8'h22);
    end
    r_av = 1; r_bv = 0;
    #1;
    chk("sa_sel", {7'd0, r_sel}, 8'd0);
    chk("sa_ar", {7'd0, r_ar}, 8'd1);
    tick();
    chk("sa_out", r_out, 8'h11);

    // Idle / drain
    r_av = 0; r_bv = 0;
    #1;
    chk("idle_sel", {7'd0, r_sel}, 8'd0);
    tick();
    chk("idle_ov", {7'd0, r_ov}, 8'd0);
    chk("idle_out", r_out, 8'h11);
    chk("idle_sel2", {7'd0, r_sel}, 8'd0);

    // Reset mid-cycle with OUT_VALID=1; B would win arbitration if not in reset
    r_av = 1;
    tick();
    chk("pre_rst_ov", {7'd0, r_ov}, 8'd1);
    r_bv = 1; r_or = 1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out", r_out, 8'h00);
    chk("arst_ov", {7'd0, r_ov}, 8'd0);
    chk("arst_sel", {7'd0, r_sel}, 8'd0);
    chk("arst_ar", {7'd0, r_ar}, 8'd0);
    chk("arst_br", {7'd0, r_br}, 8'd0);
    tick();
    chk("arst_hold_out", r_out, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("rel_sel", {7'd0, r_sel}, 8'd0);
    chk("rel_ar", {7'd0, r_ar}, 8'd1);
    tick();
    chk("rel_out", r_out, 8'h11);
    r_av = 0; r_bv = 0;

    // Fixed priority: A wins every cycle
    f_av = 1; f_bv = 1; f_or = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_sel", {7'd0, f_sel}, 8'd0);
      chk("fp_ar", {7'd0, f_ar}, 8'd1);
      chk("fp_br", {7'd0, f_br}, 8'd0);
      tick();
      chk("fp_out", f_out, 8'h11);
    end
    f_av = 0; f_bv = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
